// File: rtl/pipeline_skid.sv
// pipeline_skid: two-entry elastic stage (main + skid) between a valid/ready
// producer and consumer. i_ready comes straight from a flop, so o_ready never
// reaches i_ready combinationally. Optional stall statistics are compiled in
// when PIPELINE_SKID_STATS_EN is defined (adds o_stall_cnt).
//
// state | meaning
// EMPTY | no beat held, o_valid=0
// BUSY  | main holds the beat on o_data
// FULL  | main and skid both hold beats, i_ready=0
module pipeline_skid #(
  parameter int DATA_W = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [DATA_W-1:0] o_data
`ifdef PIPELINE_SKID_STATS_EN
  ,
  output logic [15:0]       o_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              i_ready_q;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              xfer_in;
  logic              xfer_out;

  assign i_ready  = i_ready_q;
  assign o_valid  = (state_q != EMPTY);
  assign o_data   = main_q;
  assign xfer_in  = i_valid && i_ready_q;
  assign xfer_out = o_valid && o_ready;

  // Next state and data-register loads for each occupancy case.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (xfer_in) begin
          main_d  = i_data;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (xfer_in && xfer_out) begin
          main_d = i_data;
        end else if (xfer_in) begin
          skid_d  = i_data;
          state_d = FULL;
        end else if (xfer_out) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (o_ready) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // FSM state and registered i_ready; reset discards any buffered beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      i_ready_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      i_ready_q <= (state_d != FULL);
    end
  end

  // Payload registers; contents only matter while occupied, so no reset.
  always_ff @(posedge clk) begin
    main_q <= main_d;
    skid_q <= skid_d;
  end

`ifdef PIPELINE_SKID_STATS_EN
  logic [15:0] stall_cnt_q;

  // Count cycles where a beat is offered but not taken, saturating at max.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 16'h0000;
    end else if (o_valid && !o_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'h0001;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/pipeline_skid.md
PIPELINE_SKID -- requirements
Module: pipeline_skid

Interface
REQ-001 SHALL have parameter DATA_W, default 256: payload width in bits.
REQ-002 SHALL have port clk  input  1: single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-004 SHALL have port i_valid  input  1: upstream presents i_data.
REQ-005 SHALL have port i_ready  output  1: block accepts a beat this cycle; driven directly from a flop.
REQ-006 SHALL have port i_data  input  DATA_W: upstream payload.
REQ-007 SHALL have port o_valid  output  1: o_data holds a valid beat.
REQ-008 SHALL have port o_ready  input  1: downstream accepts a beat this cycle.
REQ-009 SHALL have port o_data  output  DATA_W: downstream payload, driven from the main register.
REQ-010 SHALL have port o_stall_cnt  output  16: stall statistics; present only when PIPELINE_SKID_STATS_EN is defined.

Function
REQ-011 SHALL define transfer-in as i_valid && i_ready, and transfer-out as o_valid && o_ready.
REQ-012 SHALL hold two DATA_W registers: main (drives o_data) and skid.
REQ-013 SHALL implement a three-state FSM: EMPTY (no beat), BUSY (main full), FULL (main and skid full).
REQ-014 SHALL drive o_valid = (state != EMPTY).
REQ-015 SHALL register i_ready as (next_state != FULL), so no combinational path runs from o_ready to i_ready.
REQ-016 EMPTY: on transfer-in, main <= i_data -> BUSY; otherwise stay in EMPTY.
REQ-017 BUSY with transfer-in and transfer-out: main <= i_data, stay in BUSY.
REQ-018 BUSY with transfer-in only: skid <= i_data -> FULL; main unchanged.
REQ-019 BUSY with transfer-out only: -> EMPTY.
REQ-020 BUSY with neither: hold.
REQ-021 FULL (i_ready=0): on o_ready, main <= skid -> BUSY; otherwise hold main, skid and state.
REQ-022 SHALL give 1-cycle latency: a beat accepted on edge N is on o_data with o_valid=1 after edge N.
REQ-023 SHALL sustain full throughput (one beat per cycle) while o_ready stays high.
REQ-024 SHALL never drop, duplicate or reorder beats.
REQ-025 SHALL keep o_data stable while o_valid && !o_ready.
REQ-026 SHALL ignore i_data and i_valid whenever i_ready=0.
REQ-027 SHALL treat o_ready as don't-care while o_valid=0.
REQ-028 SHALL treat the data registers as don't-care when not occupied; they need no reset.

Reset
REQ-029 While rst_n=0: state=EMPTY, o_valid=0, i_ready=1, o_stall_cnt=0 (when present).
REQ-030 Reset asserted mid-operation SHALL discard all buffered beats immediately and asynchronously.
REQ-031 After reset is released, the first rising edge SHALL be able to accept a beat.

Configuration
REQ-032 Macro PIPELINE_SKID_STATS_EN defined: o_stall_cnt SHALL increment by 1 on each cycle with o_valid && !o_ready, saturating at 16'hFFFF; it SHALL clear only on reset.
REQ-033 Macro PIPELINE_SKID_STATS_EN undefined: the port and the counter logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-034 Stream: i_valid=1 for 4 cycles with data 1,2,3,4 and o_ready=1 -> o_data 1,2,3,4 on consecutive cycles, each one cycle after acceptance, i_ready stays 1.
REQ-035 Backpressure: BUSY holding 0xA, o_ready=0, push 0xB -> FULL, i_ready=0 next cycle; then o_ready=1 -> outputs 0xA then 0xB, i_ready returns to 1 after 0xA leaves.
REQ-036 FULL with i_valid=1 and data 0xC held for 3 cycles -> 0xC not accepted until i_ready=1; final output order is A, B, C.
REQ-037 Random i_valid/o_ready over 10000 cycles -> scoreboard shows no loss, duplication or reordering, and o_data is stable during every stall.
REQ-038 Assert rst_n=0 while FULL -> o_valid=0 and i_ready=1 immediately; no stale beat appears after release.
REQ-039 With PIPELINE_SKID_STATS_EN: hold o_valid=1, o_ready=0 for 5 cycles -> o_stall_cnt=5; force 70000 stalls -> o_stall_cnt=16'hFFFF.
